// File: rtl/ncl_pkg.sv
// Shared NCL definitions: NULL/DATA encodings and the THmn next-state rule
// used by every clocked threshold gate.
package ncl_pkg;

    localparam logic NCL_NULL = 1'b0;
    localparam logic NCL_DATA = 1'b1;

    // Widest gate in the bank; narrower gates zero-extend their inputs.
    localparam int TH_MAX_N = 4;

    // THmn rule: assert at k >= m, clear at k == 0, otherwise keep state.
    function automatic logic th_next(
        input int                  m,
        input logic [TH_MAX_N-1:0] inputs,
        input logic                state
    );
        int k;
        k = 0;
        for (int i = 0; i < TH_MAX_N; i++) begin
            if (inputs[i]) k++;
        end
        if (k >= m) begin
            th_next = NCL_DATA;
        end else if (k == 0) begin
            th_next = NCL_NULL;
        end else begin
            th_next = state;
        end
    endfunction

endpackage

// File: rtl/ncl_th_gate.sv
// Single registered THmn gate with hysteresis; cleared to NULL by init_n.
module ncl_th_gate
    import ncl_pkg::*;
#(
    parameter int M = 1,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         init_n,
    input  logic [N-1:0] a,
    output logic         z
);

    logic [TH_MAX_N-1:0] a_ext;

    always_comb begin
        a_ext        = '0;
        a_ext[N-1:0] = a;
    end

    // Hold decisions use the registered z, never combinational feedback.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            z <= NCL_NULL;
        end else begin
            z <= th_next(M, a_ext, z);
        end
    end

endmodule

// File: rtl/ncl_th_gate_bank.sv
// Bank of LANES independent TH14, TH22 and TH33 gates sharing clock and reset.
module ncl_th_gate_bank
    import ncl_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic [4*LANES-1:0] th14_a,
    output logic [LANES-1:0]   th14_z,
    input  logic [2*LANES-1:0] th22_a,
    output logic [LANES-1:0]   th22_z,
    input  logic [3*LANES-1:0] th33_a,
    output logic [LANES-1:0]   th33_z
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ncl_th_gate #(.M(1), .N(4)) u_th14 (
            .clk    (clk),
            .init_n (init_n),
            .a      (th14_a[4*i +: 4]),
            .z      (th14_z[i])
        );

        ncl_th_gate #(.M(2), .N(2)) u_th22 (
            .clk    (clk),
            .init_n (init_n),
            .a      (th22_a[2*i +: 2]),
            .z      (th22_z[i])
        );

        ncl_th_gate #(.M(3), .N(3)) u_th33 (
            .clk    (clk),
            .init_n (init_n),
            .a      (th33_a[3*i +: 3]),
            .z      (th33_z[i])
        );
    end

endmodule

// File: tb/tb_ncl_th_gate_bank.sv
// Self-checking bench for ncl_th_gate_bank with four lanes.
module tb_ncl_th_gate_bank;

    localparam int LANES = 4;

    logic               clk;
    logic               init_n;
    logic [4*LANES-1:0] th14_a;
    logic [LANES-1:0]   th14_z;
    logic [2*LANES-1:0] th22_a;
    logic [LANES-1:0]   th22_z;
    logic [3*LANES-1:0] th33_a;
    logic [LANES-1:0]   th33_z;

    int vectors     = 0;
    int miscompares = 0;

    // Expected outputs packed as {th33_z, th22_z, th14_z}.
    logic [3*LANES-1:0] exp_q[$];
    logic [LANES-1:0]   m14, m22, m33;

    ncl_th_gate_bank #(.LANES(LANES)) dut (
        .clk    (clk),
        .init_n (init_n),
        .th14_a (th14_a),
        .th14_z (th14_z),
        .th22_a (th22_a),
        .th22_z (th22_z),
        .th33_a (th33_a),
        .th33_z (th33_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_th(input int m, input int k, input logic s);
        if (k >= m) return 1'b1;
        if (k == 0) return 1'b0;
        return s;
    endfunction

    // Drive one cycle of inputs, predict the registered response, then compare.
    task automatic drive_cycle(input string tag, input logic [4*LANES-1:0] a14,
                               input logic [2*LANES-1:0] a22, input logic [3*LANES-1:0] a33);
        logic [3*LANES-1:0] got;
        logic [3*LANES-1:0] exp;
        @(negedge clk);
        th14_a = a14;
        th22_a = a22;
        th33_a = a33;
        for (int i = 0; i < LANES; i++) begin
            m14[i] = ref_th(1, $countones(a14[4*i +: 4]), m14[i]);
            m22[i] = ref_th(2, $countones(a22[2*i +: 2]), m22[i]);
            m33[i] = ref_th(3, $countones(a33[3*i +: 3]), m33[i]);
        end
        exp_q.push_back({m33, m22, m14});
        @(posedge clk);
        #1;
        got = {th33_z, th22_z, th14_z};
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, 32'(got), 32'(exp));
        end
    endtask

    initial begin
        logic [1:0] seq22[5];
        logic [2:0] seq33[6];
        logic [3:0] seq14[5];
        logic       z22[5];
        logic       z33[6];
        logic       z14[5];
        logic [4*LANES-1:0] r14;
        logic [2*LANES-1:0] r22;
        logic [3*LANES-1:0] r33;

        seq22 = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        z22   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        seq33 = '{3'b000, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
        z33   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        seq14 = '{4'b0000, 4'b0100, 4'b1111, 4'b0001, 4'b0000};
        z14   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset with every input at threshold: outputs must be NULL without a clock edge.
        init_n = 1'b0;
        th14_a = '1;
        th22_a = '1;
        th33_a = '1;
        m14 = '0;
        m22 = '0;
        m33 = '0;
        #2;
        check("reset_async", 32'({th33_z, th22_z, th14_z}), 32'd0);
        @(posedge clk);
        #1;
        check("reset_held", 32'({th33_z, th22_z, th14_z}), 32'd0);
        @(negedge clk);
        init_n = 1'b1;
        drive_cycle("reset_release_all1", '1, '1, '1);
        check("reset_release_const", 32'({th33_z, th22_z, th14_z}), 32'hfff);

        drive_cycle("clear", '0, '0, '0);

        for (int i = 0; i < 5; i++) begin
            drive_cycle("th22_seq", '0, {6'd0, seq22[i]}, '0);
            check($sformatf("th22_const_%0d", i), 32'(th22_z[0]), 32'(z22[i]));
        end
        for (int i = 0; i < 6; i++) begin
            drive_cycle("th33_seq", '0, '0, {9'd0, seq33[i]});
            check($sformatf("th33_const_%0d", i), 32'(th33_z[0]), 32'(z33[i]));
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle("th14_seq", {12'd0, seq14[i]}, '0, '0);
            check($sformatf("th14_const_%0d", i), 32'(th14_z[0]), 32'(z14[i]));
        end

        // Mid-operation reset while TH22 is holding DATA on a partial input.
        drive_cycle("mid_set", '0, 8'b0000_0011, '0);
        drive_cycle("mid_hold", '0, 8'b0000_0010, '0);
        check("mid_hold_const", 32'(th22_z[0]), 32'd1);
        @(negedge clk);
        init_n = 1'b0;
        #1;
        check("mid_reset_async", 32'({th33_z, th22_z, th14_z}), 32'd0);
        m14 = '0;
        m22 = '0;
        m33 = '0;
        #2;
        init_n = 1'b1;
        drive_cycle("mid_partial_after", '0, 8'b0000_0010, '0);
        check("mid_partial_const", 32'(th22_z[0]), 32'd0);
        drive_cycle("mid_reset_set", '0, 8'b0000_0011, '0);
        check("mid_set_const", 32'(th22_z[0]), 32'd1);

        // Lane independence on TH33.
        drive_cycle("lane_clear", '0, '0, '0);
        drive_cycle("lane2_set", '0, '0, 12'b000_111_000_000);
        check("lane2_const", 32'(th33_z), 32'h4);
        drive_cycle("lane0_partial", '0, '0, 12'b000_111_000_011);
        check("lane0_partial_const", 32'(th33_z), 32'h4);

        // Random traffic, biased toward all-0 and all-1 to exercise hysteresis.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < LANES; i++) begin
                case ($urandom_range(0, 3))
                    0: begin r14[4*i +: 4] = '0; r22[2*i +: 2] = '0; r33[3*i +: 3] = '0; end
                    1: begin r14[4*i +: 4] = '1; r22[2*i +: 2] = '1; r33[3*i +: 3] = '1; end
                    default: begin
                        r14[4*i +: 4] = 4'($urandom_range(0, 15));
                        r22[2*i +: 2] = 2'($urandom_range(0, 3));
                        r33[3*i +: 3] = 3'($urandom_range(0, 7));
                    end
                endcase
            end
            drive_cycle("random", r14, r22, r33);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
